// File: rtl/rr_arbiter_2_pkg.sv
// Shared types and constants for the two-source round-robin arbiter family.
package rr_arbiter_2_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGnt0 = 2'd1,
        StGnt1 = 2'd2
    } arb_state_e;

    localparam logic [1:0] GrantNone = 2'b00;

    function automatic logic [1:0] state_to_grant(arb_state_e st);
        logic [1:0] g;
        g = GrantNone;
        case (st)
            StGnt0:  g = 2'b01;
            StGnt1:  g = 2'b10;
            default: g = GrantNone;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/rr_arbiter_2_if.sv
// Request/grant bundle between two requesting sources and the arbiter.
interface rr_arbiter_2_if;

    logic [1:0] req;
    logic       done;
    logic [1:0] grant;
    logic       select_line;
    logic       busy;
    logic       timeout_flag;

    modport master (
        output req,
        output done,
        input  grant,
        input  select_line,
        input  busy,
        input  timeout_flag
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output select_line,
        output busy,
        output timeout_flag
    );

endinterface

// File: rtl/rr_grant_timer.sv
// Per-grant cycle counter with clear/enable, saturation and expiry outputs.
module rr_grant_timer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic sat_o,
    output logic expire_o
);

    localparam bit               TimeoutEn = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] ExpireVal = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CntMax    = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o    = (cnt_q == CntMax);
    assign expire_o = TimeoutEn && (cnt_q == ExpireVal);

endmodule

// File: rtl/rr_arbiter_2.sv
// Two-source round-robin arbiter with per-grant timeout; all outputs registered
// so the downstream mux select never glitches.
module rr_arbiter_2 #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter_2_if.slave bus
);
    import rr_arbiter_2_pkg::*;

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic [1:0] grant_q, grant_d;
    logic       sel_q, sel_d;
    logic       busy_q, busy_d;
    logic       flag_q, flag_d;

    logic       tmr_clear, tmr_en, tmr_sat, tmr_expire;
    logic       own, release_req;

    rr_grant_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (tmr_clear),
        .en_i     (tmr_en),
        .sat_o    (tmr_sat),
        .expire_o (tmr_expire)
    );

    assign own         = (state_q == StGnt1);
    assign release_req = bus.done || !bus.req[own] || tmr_expire;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        flag_d    = 1'b0;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;
        case (state_q)
            StIdle: begin
                tmr_clear = 1'b1;
                case (bus.req)
                    2'b01:   state_d = StGnt0;
                    2'b10:   state_d = StGnt1;
                    2'b11:   state_d = last_q ? StGnt0 : StGnt1;
                    default: state_d = StIdle;
                endcase
            end
            StGnt0, StGnt1: begin
                if (release_req) begin
                    tmr_clear = 1'b1;
                    last_d    = own;
                    // done wins over a simultaneous timeout; a withdrawn owner is not flagged
                    flag_d    = tmr_expire && !bus.done && bus.req[own];
                    if (bus.req[!own]) begin
                        state_d = own ? StGnt0 : StGnt1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    tmr_en = !tmr_sat;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        grant_d = state_to_grant(state_d);
        busy_d  = (state_d != StIdle);
        sel_d   = sel_q;
        if (state_d == StGnt0) begin
            sel_d = 1'b0;
        end else if (state_d == StGnt1) begin
            sel_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            grant_q <= GrantNone;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            flag_q  <= flag_d;
        end
    end

    assign bus.grant        = grant_q;
    assign bus.select_line  = sel_q;
    assign bus.busy         = busy_q;
    assign bus.timeout_flag = flag_q;

endmodule

// File: tb/tb_rr_arbiter_2.sv
// Directed and randomized bench for rr_arbiter_2 against an owner/tenure reference model.
module tb_rr_arbiter_2;

    localparam int unsigned Timeout = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rr_arbiter_2_if u_if ();

    rr_arbiter_2 #(
        .TIMEOUT (Timeout),
        .CNT_W   (5)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: who owns the path, how many cycles they have held it, who had it last.
    int m_owner  = -1;
    int m_tenure = 0;
    int m_last   = 1;
    int m_sel    = 0;
    bit m_flag   = 1'b0;

    int         wait_cnt [2];
    logic [1:0] prev_grant;
    logic       prev_sel;
    bit         prev_valid = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input logic [1:0] r, input logic d);
        int k;
        bit expired;
        if (rst) begin
            m_owner = -1; m_tenure = 0; m_last = 1; m_sel = 0; m_flag = 1'b0;
        end else begin
            m_flag = 1'b0;
            if (m_owner < 0) begin
                if (r == 2'b11)  m_owner = 1 - m_last;
                else if (r[0])   m_owner = 0;
                else if (r[1])   m_owner = 1;
                if (m_owner >= 0) m_sel = m_owner;
                m_tenure = 0;
            end else begin
                k = m_owner;
                expired = (Timeout != 0) && (m_tenure == int'(Timeout) - 1);
                if (d || !r[k] || expired) begin
                    m_flag   = expired && !d && r[k];
                    m_last   = k;
                    m_tenure = 0;
                    if (r[1-k]) begin
                        m_owner = 1 - k;
                        m_sel   = 1 - k;
                    end else begin
                        m_owner = -1;
                    end
                end else begin
                    m_tenure++;
                end
            end
        end
    endtask

    task automatic step();
        bit         in_rst;
        logic [1:0] r;
        logic [1:0] exp_grant;
        @(posedge clk);
        in_rst = !rst_n;
        r      = u_if.req;
        model_edge(in_rst, r, u_if.done);
        #1;
        exp_grant = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
        check_eq("grant", u_if.grant, exp_grant);
        check_eq("select_line", u_if.select_line, m_sel[0]);
        check_eq("busy", u_if.busy, m_owner >= 0);
        check_eq("timeout_flag", u_if.timeout_flag, m_flag);
        check_eq("grant_not_11", u_if.grant == 2'b11, 0);
        for (int k = 0; k < 2; k++) begin
            if (in_rst || !r[k] || u_if.grant[k]) wait_cnt[k] = 0;
            else wait_cnt[k]++;
            if (wait_cnt[k] != 0) check_eq("wait_bound", wait_cnt[k] > int'(Timeout) + 2, 0);
        end
        if (prev_valid && !in_rst) begin
            check_eq("sel_only_on_grant_change",
                     (u_if.select_line !== prev_sel) && (u_if.grant === prev_grant), 0);
        end
        prev_grant = u_if.grant;
        prev_sel   = u_if.select_line;
        prev_valid = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        u_if.req  = 2'b11;
        u_if.done = 1'b0;

        // Reset held with both requesting
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("t1_grant", u_if.grant, 2'b00);
            check_eq("t1_sel", u_if.select_line, 1'b0);
            check_eq("t1_busy", u_if.busy, 1'b0);
            check_eq("t1_flag", u_if.timeout_flag, 1'b0);
        end

        // First tie goes to source 0, done hands over to source 1
        rst_n = 1'b1;
        step();
        check_eq("t2_grant0", u_if.grant, 2'b01);
        check_eq("t2_sel0", u_if.select_line, 1'b0);
        u_if.done = 1'b1;
        step();
        check_eq("t2_grant1", u_if.grant, 2'b10);
        check_eq("t2_sel1", u_if.select_line, 1'b1);
        u_if.done = 1'b0;

        // Timeout on a held request
        rst_n = 1'b0;
        step();
        rst_n    = 1'b1;
        u_if.req = 2'b01;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("t3_hold_grant", u_if.grant, 2'b01);
            check_eq("t3_hold_flag", u_if.timeout_flag, 1'b0);
        end
        step();
        check_eq("t3_bubble_grant", u_if.grant, 2'b00);
        check_eq("t3_bubble_flag", u_if.timeout_flag, 1'b1);
        step();
        check_eq("t3_regrant", u_if.grant, 2'b01);
        check_eq("t3_regrant_flag", u_if.timeout_flag, 1'b0);

        // Owner 1 withdraws while 0 waits
        rst_n = 1'b0;
        step();
        rst_n    = 1'b1;
        u_if.req = 2'b10;
        step();
        check_eq("t4_grant1", u_if.grant, 2'b10);
        u_if.req = 2'b01;
        step();
        check_eq("t4_handover", u_if.grant, 2'b01);
        check_eq("t4_busy", u_if.busy, 1'b1);
        check_eq("t4_flag", u_if.timeout_flag, 1'b0);

        // done coinciding with expiry, then reset mid-grant
        rst_n = 1'b0;
        step();
        rst_n    = 1'b1;
        u_if.req = 2'b01;
        for (int i = 0; i < 4; i++) step();
        u_if.done = 1'b1;
        step();
        check_eq("t5_done_grant", u_if.grant, 2'b00);
        check_eq("t5_done_flag", u_if.timeout_flag, 1'b0);
        u_if.done = 1'b0;
        step();
        check_eq("t5_regrant", u_if.grant, 2'b01);
        rst_n = 1'b0;
        step();
        check_eq("t5_rst_grant", u_if.grant, 2'b00);
        check_eq("t5_rst_busy", u_if.busy, 1'b0);
        check_eq("t5_rst_flag", u_if.timeout_flag, 1'b0);
        rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 3) == 0) u_if.req = 2'($urandom_range(0, 3));
            u_if.done = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
